seg_scan: RTL and testbench

Time-division display driver for the stopwatch's six-digit 7-segment display. It consumes the six parallel segment patterns from the running/lap display multiplexer and drives one shared 7-bit segment bus plus six digit enables. Digits are lit one at a time, with an optional blanking gap between them to suppress ghosting. All six inputs are snapshotted at each frame start, so a lap/run switch never tears a frame.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/seg_scan.sv | 132 +++++++++++++
 tb/tb_seg_scan.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch display path.
package stopwatch_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } scan_state_t;

endpackage

// File: rtl/seg_scan.sv
// Time-division driver for a six-digit 7-segment display with optional
// inter-digit blanking; all six patterns are snapshotted at each frame start.
module seg_scan
    import stopwatch_pkg::*;
#(
    parameter int DWELL          = 50000,
    parameter int BLANK          = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [SEG_W-1:0]      d1,
    input  logic [SEG_W-1:0]      d2,
    input  logic [SEG_W-1:0]      d3,
    input  logic [SEG_W-1:0]      d4,
    input  logic [SEG_W-1:0]      d5,
    input  logic [SEG_W-1:0]      d6,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] dig,
    output logic                  frame_start,
    output scan_state_t           scan_state
);

    localparam int CNT_MAX = (DWELL > BLANK) ? ((DWELL > 2) ? DWELL : 2)
                                             : ((BLANK > 2) ? BLANK : 2);
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

    // With no blanking gap every digit change goes straight to SHOW.
    localparam scan_state_t ENTRY = (BLANK > 0) ? S_BLANK : S_SHOW;

    localparam logic [SEG_W-1:0]      SEG_POL = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    scan_state_t           state_q, state_n;
    logic [2:0]            idx, idx_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [SEG_W-1:0]      snap [NUM_DIGITS];
    logic [SEG_W-1:0]      d_in [NUM_DIGITS];
    logic                  load;
    logic [SEG_W-1:0]      shown;
    logic [SEG_W-1:0]      seg_n;
    logic [NUM_DIGITS-1:0] dig_n;

    assign scan_state = state_q;

    always_comb begin
        d_in[0] = d1;
        d_in[1] = d2;
        d_in[2] = d3;
        d_in[3] = d4;
        d_in[4] = d5;
        d_in[5] = d6;
    end

    always_comb begin
        state_n = state_q;
        idx_n   = idx;
        cnt_n   = cnt + 1'b1;
        load    = 1'b0;
        if (!en) begin
            state_n = S_IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    load    = 1'b1;
                    idx_n   = '0;
                    cnt_n   = '0;
                    state_n = ENTRY;
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt_n   = '0;
                        state_n = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        cnt_n   = '0;
                        state_n = ENTRY;
                        if (idx == LAST_IDX) begin
                            idx_n = '0;
                            load  = 1'b1;
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        // On a snapshot edge the digit shown next comes from the live inputs.
        shown = load ? d_in[idx_n] : snap[idx_n];
        seg_n = SEG_BLANK;
        dig_n = '0;
        if (state_n == S_SHOW) begin
            seg_n = shown;
            dig_n = NUM_DIGITS'(1) << idx_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            frame_start <= 1'b0;
            seg         <= SEG_BLANK ^ SEG_POL;
            dig         <= DIG_POL;
            for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= SEG_BLANK;
        end else begin
            state_q     <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            frame_start <= load;
            seg         <= seg_n ^ SEG_POL;
            dig         <= dig_n ^ DIG_POL;
            if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= d_in[i];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: three parameterisations driven side by side and
// compared against a frame-arithmetic model of the scan.
module tb_seg_scan;
    import stopwatch_pkg::*;

    localparam int DW = 4;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b, en_c;
    logic [6:0] d [6];

    logic [6:0] seg_a, seg_b, seg_c;
    logic [5:0] dig_a, dig_b, dig_c;
    logic       fs_a, fs_b, fs_c;
    scan_state_t st_a, st_b, st_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan #(.DWELL(DW), .BLANK(BL), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en_a),
        .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]), .d5(d[4]), .d6(d[5]),
        .seg(seg_a), .dig(dig_a), .frame_start(fs_a), .scan_state(st_a)
    );

    seg_scan #(.DWELL(DW), .BLANK(0), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_b (
        .clk(clk), .rst(rst), .en(en_b),
        .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]), .d5(d[4]), .d6(d[5]),
        .seg(seg_b), .dig(dig_b), .frame_start(fs_b), .scan_state(st_b)
    );

    seg_scan #(.DWELL(DW), .BLANK(BL), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en_c),
        .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]), .d5(d[4]), .d6(d[5]),
        .seg(seg_c), .dig(dig_c), .frame_start(fs_c), .scan_state(st_c)
    );

    // t = edges since the enabling edge (t=0 is that edge). A frame is six
    // slots of b blank cycles followed by dw lit cycles.
    function automatic void model(input int t, input int b, input int dw,
                                  output logic show, output int didx, output logic fs);
        int slot;
        int pos;
        slot = b + dw;
        pos  = t % (6 * slot);
        didx = pos / slot;
        show = (pos % slot) >= b;
        fs   = (pos == 0);
    endfunction

    task automatic test_reset();
        checks++;
        if ({seg_a, dig_a, fs_a} !== 14'h0) begin
            errors++;
            $display("FAIL reset_a got seg=%h dig=%b fs=%b exp 00/000000/0", seg_a, dig_a, fs_a);
        end
        checks++;
        if ({seg_c, dig_c, fs_c} !== {7'h7F, 6'h3F, 1'b0}) begin
            errors++;
            $display("FAIL reset_pol got seg=%h dig=%h fs=%b exp 7f/3f/0", seg_c, dig_c, fs_c);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) d[k] = 7'h55;
        @(negedge clk);
        en_a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (dig_a !== 6'b000001) begin
            errors++;
            $display("FAIL reset_pre_show got dig=%b exp 000001", dig_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({seg_a, dig_a, fs_a} !== 14'h0) begin
            errors++;
            $display("FAIL reset_async got seg=%h dig=%b fs=%b exp 00/000000/0", seg_a, dig_a, fs_a);
        end
        checks++;
        if (st_a !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d exp %0d", st_a, S_IDLE);
        end
        en_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [6:0]  snap_m [6];
        logic        show, efs;
        int          di;
        logic [13:0] exp_v;
        d[0] = 7'h3F; d[1] = 7'h06; d[2] = 7'h5B;
        d[3] = 7'h4F; d[4] = 7'h66; d[5] = 7'h6D;
        @(negedge clk);
        en_a = 1'b1;
        for (int t = 0; t < 80; t++) begin
            @(posedge clk);
            model(t, BL, DW, show, di, efs);
            if (efs) for (int k = 0; k < 6; k++) snap_m[k] = d[k];
            #1;
            exp_v = {show ? snap_m[di] : 7'h00, show ? (6'b000001 << di) : 6'h00, efs};
            checks++;
            if ({seg_a, dig_a, fs_a} !== exp_v) begin
                errors++;
                $display("FAIL basic t=%0d got seg=%h dig=%b fs=%b exp %h", t, seg_a, dig_a, fs_a, exp_v);
            end
        end
        @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_snapshot();
        logic [6:0]  snap_m [6];
        logic        show, efs;
        int          di;
        logic [13:0] exp_v;
        for (int k = 0; k < 6; k++) d[k] = 7'($urandom_range(0, 126));
        @(negedge clk);
        en_a = 1'b1;
        for (int t = 0; t < 80; t++) begin
            @(posedge clk);
            model(t, BL, DW, show, di, efs);
            if (efs) for (int k = 0; k < 6; k++) snap_m[k] = d[k];
            #1;
            exp_v = {show ? snap_m[di] : 7'h00, show ? (6'b000001 << di) : 6'h00, efs};
            checks++;
            if ({seg_a, dig_a, fs_a} !== exp_v) begin
                errors++;
                $display("FAIL snapshot t=%0d got seg=%h dig=%b fs=%b exp %h", t, seg_a, dig_a, fs_a, exp_v);
            end
            @(negedge clk);
            // Digit 3 is lit from t=14; all inputs change under it.
            if (t == 14) for (int k = 0; k < 6; k++) d[k] = 7'h7F;
        end
        en_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [6:0]  snap_m [6];
        logic        show, efs;
        int          di;
        logic [13:0] exp_v;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 6; k++) d[k] = 7'($urandom);
            @(negedge clk);
            en_a = 1'b1;
            for (int t = 0; t < 60; t++) begin
                @(posedge clk);
                model(t, BL, DW, show, di, efs);
                if (efs) for (int k = 0; k < 6; k++) snap_m[k] = d[k];
                #1;
                exp_v = {show ? snap_m[di] : 7'h00, show ? (6'b000001 << di) : 6'h00, efs};
                checks++;
                if ({seg_a, dig_a, fs_a} !== exp_v) begin
                    errors++;
                    $display("FAIL random r=%0d t=%0d got seg=%h dig=%b fs=%b exp %h", r, t, seg_a, dig_a, fs_a, exp_v);
                end
                @(negedge clk);
                for (int k = 0; k < 6; k++)
                    if ($urandom_range(0, 4) == 0) d[k] = 7'($urandom);
            end
            en_a = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_enable_drop();
        logic [6:0]  snap_m [6];
        logic        show, efs;
        int          di;
        logic [13:0] exp_v;
        for (int k = 0; k < 6; k++) d[k] = 7'($urandom);
        @(negedge clk);
        en_a = 1'b1;
        for (int t = 0; t <= 26; t++) begin
            @(posedge clk);
            model(t, BL, DW, show, di, efs);
            if (efs) for (int k = 0; k < 6; k++) snap_m[k] = d[k];
            #1;
            exp_v = {show ? snap_m[di] : 7'h00, show ? (6'b000001 << di) : 6'h00, efs};
            checks++;
            if ({seg_a, dig_a, fs_a} !== exp_v) begin
                errors++;
                $display("FAIL drop_run t=%0d got seg=%h dig=%b fs=%b exp %h", t, seg_a, dig_a, fs_a, exp_v);
            end
        end
        @(negedge clk);
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({seg_a, dig_a, fs_a} !== 14'h0 || st_a !== S_IDLE) begin
                errors++;
                $display("FAIL drop_off i=%0d got seg=%h dig=%b fs=%b st=%0d exp off/idle", i, seg_a, dig_a, fs_a, st_a);
            end
        end
        for (int k = 0; k < 6; k++) d[k] = 7'($urandom);
        @(negedge clk);
        en_a = 1'b1;
        for (int t = 0; t < 14; t++) begin
            @(posedge clk);
            model(t, BL, DW, show, di, efs);
            if (efs) for (int k = 0; k < 6; k++) snap_m[k] = d[k];
            #1;
            exp_v = {show ? snap_m[di] : 7'h00, show ? (6'b000001 << di) : 6'h00, efs};
            checks++;
            if ({seg_a, dig_a, fs_a} !== exp_v) begin
                errors++;
                $display("FAIL drop_restart t=%0d got seg=%h dig=%b fs=%b exp %h", t, seg_a, dig_a, fs_a, exp_v);
            end
        end
        @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_blank0();
        logic [6:0]  snap_m [6];
        logic        show, efs;
        int          di;
        logic [13:0] exp_v;
        for (int k = 0; k < 6; k++) d[k] = 7'($urandom);
        @(negedge clk);
        en_b = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            model(t, 0, DW, show, di, efs);
            if (efs) for (int k = 0; k < 6; k++) snap_m[k] = d[k];
            #1;
            exp_v = {show ? snap_m[di] : 7'h00, show ? (6'b000001 << di) : 6'h00, efs};
            checks++;
            if ({seg_b, dig_b, fs_b} !== exp_v) begin
                errors++;
                $display("FAIL blank0 t=%0d got seg=%h dig=%b fs=%b exp %h", t, seg_b, dig_b, fs_b, exp_v);
            end
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 5)] = 7'($urandom);
        end
        en_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_polarity();
        logic [6:0]  snap_m [6];
        logic        show, efs;
        int          di;
        logic [13:0] exp_v;
        for (int k = 0; k < 6; k++) d[k] = 7'($urandom);
        d[0] = 7'h06;
        @(negedge clk);
        en_c = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            model(t, BL, DW, show, di, efs);
            if (efs) for (int k = 0; k < 6; k++) snap_m[k] = d[k];
            #1;
            exp_v = {~(show ? snap_m[di] : 7'h00), ~(show ? (6'b000001 << di) : 6'h00), efs};
            checks++;
            if ({seg_c, dig_c, fs_c} !== exp_v) begin
                errors++;
                $display("FAIL polarity t=%0d got seg=%h dig=%h fs=%b exp %h", t, seg_c, dig_c, fs_c, exp_v);
            end
            if (t == 2) begin
                checks++;
                if ({seg_c, dig_c} !== {7'h79, 6'h3E}) begin
                    errors++;
                    $display("FAIL polarity_digit1 got seg=%h dig=%h exp 79/3e", seg_c, dig_c);
                end
            end
        end
        @(negedge clk);
        en_c = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        en_c = 1'b0;
        for (int k = 0; k < 6; k++) d[k] = 7'h00;
        #12;
        test_reset();
        test_basic();
        test_snapshot();
        test_random();
        test_enable_drop();
        test_blank0();
        test_polarity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
